// File: rtl/coef_entry_ctrl.sv
// Keypad entry sequencer for polynomial coefficients: builds a signed BCD entry,
// converts it to two's complement, writes it to a slot, then kicks the plotter.
module coef_entry_ctrl #(
  parameter int NUM_DIGITS = 5,
  parameter int NUM_COEF   = 3,
  parameter int COEF_W     = 18
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_digit,
  input  logic [3:0]                    digit_val,
  input  logic                          key_sign,
  input  logic                          key_back,
  input  logic                          key_clear,
  input  logic                          key_enter,
  output logic [NUM_DIGITS*4-1:0]       disp_bcd,
  output logic                          disp_neg,
  output logic [$clog2(NUM_COEF)-1:0]   coef_idx,
  output logic                          wr_valid,
  output logic [$clog2(NUM_COEF)-1:0]   wr_idx,
  output logic [COEF_W-1:0]             wr_data,
  input  logic                          wr_ready,
  output logic                          plot_start,
  input  logic                          plot_done,
  output logic                          busy
);

  localparam int BUF_W = NUM_DIGITS * 4;
  localparam int IDX_W = $clog2(NUM_COEF);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);

  localparam logic [2:0] S_ENTRY     = 3'd0;
  localparam logic [2:0] S_CONVERT   = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_PLOT_REQ  = 3'd3;
  localparam logic [2:0] S_PLOT_WAIT = 3'd4;

  logic [2:0]        state;
  logic [COEF_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        cur_digit;

  function automatic logic [COEF_W-1:0] mul10_add(input logic [COEF_W-1:0] a,
                                                  input logic [3:0] d);
    return (a << 3) + (a << 1) + COEF_W'(d);
  endfunction

  // Negating zero yields zero, so a "-0" entry is written as plain 0.
  function automatic logic signed [COEF_W-1:0] to_twos(input logic neg,
                                                       input logic [COEF_W-1:0] mag);
    logic signed [COEF_W-1:0] s;
    s = signed'(mag);
    return neg ? -s : s;
  endfunction

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(cnt) == NUM_DIGITS - 1 - i) cur_digit = disp_bcd[4*i +: 4];
    end
  end

  assign busy = (state != S_ENTRY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_ENTRY;
      disp_bcd   <= '0;
      disp_neg   <= 1'b0;
      coef_idx   <= '0;
      wr_valid   <= 1'b0;
      wr_idx     <= '0;
      wr_data    <= '0;
      plot_start <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_ENTRY: begin
          if (key_clear) begin
            disp_bcd <= '0;
            disp_neg <= 1'b0;
          end else if (key_enter) begin
            acc   <= '0;
            cnt   <= '0;
            state <= S_CONVERT;
          end else if (key_back) begin
            disp_bcd <= {4'd0, disp_bcd[BUF_W-1:4]};
          end else if (key_sign) begin
            disp_neg <= ~disp_neg;
          end else if (key_digit && digit_val <= 4'd9 && disp_bcd[BUF_W-1 -: 4] == 4'd0) begin
            disp_bcd <= {disp_bcd[BUF_W-5:0], digit_val};
          end
        end
        // MSD-first accumulation, then one extra cycle to publish the result
        S_CONVERT: begin
          if (cnt == CNT_W'(NUM_DIGITS)) begin
            wr_data  <= to_twos(disp_neg, acc);
            wr_idx   <= coef_idx;
            wr_valid <= 1'b1;
            state    <= S_WRITE;
          end else begin
            acc <= mul10_add(acc, cur_digit);
            cnt <= cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            disp_bcd <= '0;
            disp_neg <= 1'b0;
            if (coef_idx == LAST_IDX) begin
              plot_start <= 1'b1;
              state      <= S_PLOT_REQ;
            end else begin
              coef_idx <= coef_idx + 1'b1;
              state    <= S_ENTRY;
            end
          end
        end
        S_PLOT_REQ: begin
          plot_start <= 1'b0;
          state      <= S_PLOT_WAIT;
        end
        S_PLOT_WAIT: begin
          if (plot_done) begin
            coef_idx <= '0;
            state    <= S_ENTRY;
          end
        end
        default: state <= S_ENTRY;
      endcase
    end
  end

endmodule
